ov5640_capture: RTL and testbench

OV5640_CAPTURE -- requirements
Module: ov5640_capture

---
 rtl/ov5640_capture.sv | 197 +++++++++++++++++++
 tb/tb_ov5640_capture.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_capture.sv
// ov5640_capture
//   Captures the OV5640 DVP byte stream into 16-bit pixel words, with a
//   per-frame crop window and a post-reset frame skip. The skip lets the
//   sensor's auto-exposure settle before any frame is captured.
//
// Ports
//   ov5640_pclk      sensor pixel clock; all logic uses its rising edge
//   s_rst_n          asynchronous active-low reset
//   ov5640_href      line valid
//   ov5640_vsync     frame sync; a rising edge marks the frame boundary
//   ov5640_data[7:0] sensor byte
//   capture_en       capture enable, sampled only at frame boundaries
//   mode             0 = two bytes per pixel (RGB565), 1 = one byte (RAW8/Y8)
//   x_start/x_end    inclusive crop columns, in pixels
//   y_start/y_end    inclusive crop rows, in lines
//   m_data[15:0]     captured pixel word
//   m_wr_en          write strobe for m_data
//   m_sof            flags the first write of a captured frame
//   m_eof            one-cycle pulse at the boundary ending a captured frame
//   line_err         one-cycle pulse when a line ends on a half pixel (mode 0)
//   frame_cnt        count of completed captured frames, wrapping
//   dbg_state[1:0]   capture FSM state (0 = SKIP, 1 = IDLE, 2 = ACTIVE)
//
// Output handshake: the pixel sink has no back-pressure. m_wr_en is a
// one-cycle strobe and m_data is valid only in that cycle; m_sof is valid
// only with m_wr_en. m_eof is its own one-cycle strobe.
module ov5640_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter int CNT_W       = 12,
  parameter int FCNT_W      = 8
) (
  input  logic              ov5640_pclk,
  input  logic              s_rst_n,
  input  logic              ov5640_href,
  input  logic              ov5640_vsync,
  input  logic [7:0]        ov5640_data,
  input  logic              capture_en,
  input  logic              mode,
  input  logic [CNT_W-1:0]  x_start,
  input  logic [CNT_W-1:0]  x_end,
  input  logic [CNT_W-1:0]  y_start,
  input  logic [CNT_W-1:0]  y_end,
  output logic [15:0]       m_data,
  output logic              m_wr_en,
  output logic              m_sof,
  output logic              m_eof,
  output logic              line_err,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // The skip counter only needs to reach SKIP_FRAMES; one spare bit keeps
  // the width legal when SKIP_FRAMES is 0.
  localparam int SK_W = $clog2(SKIP_FRAMES + 1) + 1;
  localparam logic [SK_W-1:0] SKIP_LAST = SK_W'(SKIP_FRAMES);

  state_t            state, state_nxt;
  logic [SK_W-1:0]   skip_cnt, skip_cnt_nxt;

  logic              vs_d;
  logic              href_d;
  logic              byte_flag;
  logic [7:0]        first_byte;
  logic [CNT_W-1:0]  x_cnt, y_cnt;
  logic              mode_l;
  logic [CNT_W-1:0]  xs_l, xe_l, ys_l, ye_l;
  logic              sof_pend;
  logic              wrote_any;

  logic              vs_pos;
  logic              href_fall;
  logic              pix_done;
  logic              in_win;
  logic              wr_fire;

  assign vs_pos    = ov5640_vsync & ~vs_d;
  assign href_fall = href_d & ~ov5640_href;
  assign pix_done  = ov5640_href & (mode_l | byte_flag);
  // An inverted window (end < start) can never match, so it yields no writes.
  assign in_win    = (x_cnt >= xs_l) && (x_cnt <= xe_l) &&
                     (y_cnt >= ys_l) && (y_cnt <= ye_l);
  // The frame boundary wins over a pixel completing in the same cycle.
  assign wr_fire   = (state == ST_ACTIVE) & pix_done & in_win & ~vs_pos;
  assign dbg_state = state;

  // Capture FSM: state changes only at frame boundaries, so capture_en
  // edges inside a frame can neither cut a frame short nor start one late.
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= ST_SKIP;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    if (vs_pos) begin
      case (state)
        ST_SKIP: begin
          // SKIP_FRAMES boundaries are discarded; the next one may start capture.
          if (skip_cnt >= SKIP_LAST) begin
            state_nxt = capture_en ? ST_ACTIVE : ST_IDLE;
          end else begin
            skip_cnt_nxt = skip_cnt + SK_W'(1);
          end
        end
        ST_IDLE: begin
          if (capture_en) state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!capture_en) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_SKIP;
      endcase
    end
  end

  // Datapath: byte pairing, counters, frame-latched settings and outputs.
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vs_d       <= 1'b0;
      href_d     <= 1'b0;
      byte_flag  <= 1'b0;
      first_byte <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      mode_l     <= 1'b0;
      xs_l       <= '0;
      xe_l       <= '0;
      ys_l       <= '0;
      ye_l       <= '0;
      sof_pend   <= 1'b0;
      wrote_any  <= 1'b0;
      m_data     <= '0;
      m_wr_en    <= 1'b0;
      m_sof      <= 1'b0;
      m_eof      <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vs_d      <= ov5640_vsync;
      href_d    <= ov5640_href;
      // Dropping href realigns the byte phase, so a half pixel never leaks
      // into the next line.
      byte_flag <= ov5640_href ? ~byte_flag : 1'b0;
      if (ov5640_href && !byte_flag) first_byte <= ov5640_data;

      m_wr_en  <= wr_fire;
      m_sof    <= wr_fire & sof_pend;
      m_eof    <= 1'b0;
      line_err <= href_fall & byte_flag & ~mode_l;

      if (wr_fire) begin
        m_data    <= mode_l ? {8'h00, ov5640_data} : {first_byte, ov5640_data};
        wrote_any <= 1'b1;
        sof_pend  <= 1'b0;
      end

      if (vs_pos) begin
        mode_l    <= mode;
        xs_l      <= x_start;
        xe_l      <= x_end;
        ys_l      <= y_start;
        ye_l      <= y_end;
        x_cnt     <= '0;
        y_cnt     <= '0;
        wrote_any <= 1'b0;
        sof_pend  <= (state_nxt == ST_ACTIVE);
        // Frames that produced nothing (empty crop) are not counted.
        if (state == ST_ACTIVE && wrote_any) begin
          m_eof     <= 1'b1;
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end
      end else begin
        if (!ov5640_href) begin
          x_cnt <= '0;
        end else if (pix_done && x_cnt != '1) begin
          x_cnt <= x_cnt + CNT_W'(1);
        end
        if (href_fall && y_cnt != '1) begin
          y_cnt <= y_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ov5640_capture.sv
// Testbench for ov5640_capture: directed scenarios followed by randomized
// frames, all checked against a frame/line-level model of the capture rules.
module tb_ov5640_capture;

  localparam int SKIP = 2;
  localparam int CW   = 4;
  localparam int FW   = 3;
  localparam int XMAX = (1 << CW) - 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_rst_n;
  logic          href, vsync, capture_en, mode;
  logic [7:0]    data;
  logic [CW-1:0] x_start, x_end, y_start, y_end;
  logic [15:0]   m_data;
  logic          m_wr_en, m_sof, m_eof, line_err;
  logic [FW-1:0] frame_cnt;
  logic [1:0]    dbg_state;

  ov5640_capture #(.SKIP_FRAMES(SKIP), .CNT_W(CW), .FCNT_W(FW)) dut (
    .ov5640_pclk (clk),
    .s_rst_n     (s_rst_n),
    .ov5640_href (href),
    .ov5640_vsync(vsync),
    .ov5640_data (data),
    .capture_en  (capture_en),
    .mode        (mode),
    .x_start     (x_start),
    .x_end       (x_end),
    .y_start     (y_start),
    .y_end       (y_end),
    .m_data      (m_data),
    .m_wr_en     (m_wr_en),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .line_err    (line_err),
    .frame_cnt   (frame_cnt),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  int   skip_seen, fcnt_m, y_m, exp_lerr;
  bit   past_skip, act_m, mode_m, wrote_m, sof_m, rand_ports;
  int   xs_m, xe_m, ys_m, ye_m;
  logic [16:0]   exp_q[$];   // {sof, data}
  logic [FW-1:0] eof_q[$];   // frame_cnt expected with each m_eof
  logic [7:0]    line_q[$];

  task automatic model_reset();
    skip_seen = 0; past_skip = 0; act_m = 0; fcnt_m = 0;
    wrote_m = 0; sof_m = 0; y_m = 0; mode_m = 0;
    xs_m = 0; xe_m = 0; ys_m = 0; ye_m = 0;
    exp_q.delete(); eof_q.delete();
  endtask

  // Frame boundary: close the old frame, decide the new one, latch settings.
  task automatic model_vs();
    if (act_m && wrote_m) begin
      fcnt_m = (fcnt_m + 1) % (1 << FW);
      eof_q.push_back(FW'(fcnt_m));
    end
    if (!past_skip) begin
      if (skip_seen == SKIP) begin
        past_skip = 1;
        act_m = capture_en;
      end else begin
        skip_seen++;
        act_m = 0;
      end
    end else begin
      act_m = capture_en;
    end
    mode_m = mode;
    xs_m = x_start; xe_m = x_end; ys_m = y_start; ye_m = y_end;
    wrote_m = 0; sof_m = 1; y_m = 0;
  endtask

  task automatic model_pixel(input int x, input logic [15:0] d);
    int xx, yy;
    xx = (x > XMAX) ? XMAX : x;
    yy = (y_m > XMAX) ? XMAX : y_m;
    if (act_m && xx >= xs_m && xx <= xe_m && yy >= ys_m && yy <= ye_m) begin
      exp_q.push_back({sof_m, d});
      sof_m = 0;
      wrote_m = 1;
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  int          wr_obs = 0;
  int          lerr_obs = 0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    if (s_rst_n) begin
      if (m_wr_en) begin
        logic [16:0] e;
        wr_obs++;
        last_data = m_data;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got m_data=%h, expected no write", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e[15:0]);
          chk("m_sof", m_sof, e[16]);
        end
      end else begin
        chk("m_sof_without_wr", m_sof, 0);
      end
      if (m_eof) begin
        if (eof_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_eof: got m_eof=1 frame_cnt=%0d, expected no eof", frame_cnt);
        end else begin
          chk("frame_cnt_at_eof", frame_cnt, eof_q.pop_front());
        end
      end
      if (line_err) lerr_obs++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic rand_ports_set();
    int a, b, c, d;
    capture_en = ($urandom_range(0, 3) != 0);
    mode = $urandom_range(0, 1);
    a = $urandom_range(0, XMAX); b = $urandom_range(0, XMAX);
    c = $urandom_range(0, 4);    d = $urandom_range(0, 4);
    if ($urandom_range(0, 5) == 0) begin
      x_start = CW'(a > b ? a : b); x_end = CW'(a > b ? b : a);
    end else begin
      x_start = CW'(a < b ? a : b); x_end = CW'(a < b ? b : a);
    end
    y_start = CW'(c < d ? c : d); y_end = CW'(c < d ? d : c);
  endtask

  task automatic full_window();
    x_start = '0; x_end = CW'(XMAX); y_start = '0; y_end = CW'(XMAX);
  endtask

  task automatic fill_line(input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends line_q as one href burst. With vs_first the frame boundary lands
  // on the first byte of the line.
  task automatic send_line(input bit vs_first);
    int idx;
    logic [7:0] prev, b;
    idx = 0; prev = '0;
    for (int i = 0; i < line_q.size(); i++) begin
      b = line_q[i];
      href = 1'b1; data = b;
      if (i == 0 && vs_first) begin
        vsync = 1'b1;
        model_vs();
      end
      if (!(i == 0 && vs_first && mode_m)) begin
        if (!mode_m) begin
          if (idx % 2 == 1) model_pixel(idx / 2, {prev, b});
          prev = b;
        end else begin
          model_pixel(idx, {8'h00, b});
        end
        idx++;
      end
      if (rand_ports && !(i == 0 && vs_first) && $urandom_range(0, 7) == 0) rand_ports_set();
      @(negedge clk);
    end
    href = 1'b0;
    if (!mode_m && (idx % 2 == 1)) exp_lerr++;
    y_m++;
    @(negedge clk);
    @(negedge clk);
    chk("line_drain", exp_q.size(), 0);
    if (vs_first) vsync = 1'b0;
  endtask

  task automatic vsync_pulse();
    chk("line_err_count", lerr_obs, exp_lerr);
    vsync = 1'b1;
    model_vs();
    @(negedge clk);
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("eof_drain", eof_q.size(), 0);
  endtask

  task automatic rand_frame_lines(input int nlines, input int len);
    for (int l = 0; l < nlines; l++) begin
      fill_line(len);
      send_line(1'b0);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  int w0, l0;

  initial begin
    s_rst_n = 1'b0; href = 1'b0; vsync = 1'b0; data = '0;
    capture_en = 1'b1; mode = 1'b0; rand_ports = 0; exp_lerr = 0;
    full_window();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_m_wr_en", m_wr_en, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_m_eof", m_eof, 0);
    s_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two discarded frames, then one 4x2 RGB565 frame.
    w0 = wr_obs;
    vsync_pulse(); rand_frame_lines(2, 8);
    vsync_pulse(); rand_frame_lines(2, 8);
    chk("skip_no_writes", wr_obs - w0, 0);
    vsync_pulse(); rand_frame_lines(2, 8);
    vsync_pulse();
    chk("first_frame_writes", wr_obs - w0, 8);
    chk("first_frame_cnt", frame_cnt, 1);

    // Byte packing in both modes.
    w0 = wr_obs;
    line_q = '{8'hA1, 8'hB2}; send_line(1'b0);
    chk("mode0_pack", last_data, 16'hA1B2);
    chk("mode0_one_write", wr_obs - w0, 1);
    mode = 1'b1;
    vsync_pulse();
    line_q = '{8'h5C}; send_line(1'b0);
    chk("mode1_pack", last_data, 16'h005C);

    // Crop x 1..2, y 1..1 on a 4x3 frame; byte value encodes {y, x}.
    x_start = 4'd1; x_end = 4'd2; y_start = 4'd1; y_end = 4'd1;
    vsync_pulse();
    w0 = wr_obs;
    for (int y = 0; y < 3; y++) begin
      line_q.delete();
      for (int x = 0; x < 4; x++) line_q.push_back(8'(y * 16 + x));
      send_line(1'b0);
    end
    chk("crop_writes", wr_obs - w0, 2);
    chk("crop_last_pixel", last_data, 16'h0012);

    // Inverted crop window: no writes, no eof.
    x_start = 4'd3; x_end = 4'd2; y_start = 4'd0; y_end = 4'd15;
    vsync_pulse();
    w0 = wr_obs;
    rand_frame_lines(3, 4);
    mode = 1'b0; full_window();
    vsync_pulse();
    chk("empty_crop_writes", wr_obs - w0, 0);
    chk("empty_crop_frame_cnt", frame_cnt, 4);

    // Odd-length RGB565 line, then a line that must start on a fresh pair.
    w0 = wr_obs; l0 = lerr_obs;
    fill_line(7); send_line(1'b0);
    chk("odd_line_writes", wr_obs - w0, 3);
    chk("odd_line_err", lerr_obs - l0, 1);
    line_q = '{8'h11, 8'h22, 8'h33, 8'h44}; send_line(1'b0);
    chk("phase_after_odd", last_data, 16'h3344);

    // capture_en dropped mid-frame, then re-asserted mid-frame.
    vsync_pulse();
    w0 = wr_obs;
    fill_line(8); send_line(1'b0);
    capture_en = 1'b0;
    fill_line(8); send_line(1'b0);
    chk("en_drop_frame_completes", wr_obs - w0, 8);
    vsync_pulse();
    w0 = wr_obs;
    fill_line(8); send_line(1'b0);
    capture_en = 1'b1;
    fill_line(8); send_line(1'b0);
    chk("en_off_frame_writes", wr_obs - w0, 0);
    vsync_pulse();
    fill_line(8); send_line(1'b0);
    chk("en_resume_writes", wr_obs - w0, 4);

    // Frame boundary coinciding with the first byte of a RAW8 line.
    mode = 1'b1;
    w0 = wr_obs;
    fill_line(5); send_line(1'b1);
    chk("vs_href_writes", wr_obs - w0, 4);

    // Asynchronous reset mid-line while capturing.
    line_q = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      href = 1'b1; data = line_q[i];
      model_pixel(i, {8'h00, line_q[i]});
      @(negedge clk);
    end
    data = 8'h04;
    #2 s_rst_n = 1'b0;
    #1;
    chk("async_rst_m_wr_en", m_wr_en, 0);
    chk("async_rst_m_data", m_data, 0);
    chk("async_rst_m_sof", m_sof, 0);
    chk("async_rst_m_eof", m_eof, 0);
    chk("async_rst_line_err", line_err, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    chk("pre_rst_drain", exp_q.size(), 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    href = 1'b0; s_rst_n = 1'b1;
    @(negedge clk);
    capture_en = 1'b1; mode = 1'b1; full_window();
    w0 = wr_obs;
    vsync_pulse(); rand_frame_lines(1, 4);
    vsync_pulse(); rand_frame_lines(1, 4);
    chk("post_rst_skip", wr_obs - w0, 0);
    vsync_pulse(); rand_frame_lines(1, 4);
    chk("post_rst_resume", wr_obs - w0, 4);

    // Randomized frames: modes, crops, enables and mid-frame port changes.
    rand_ports = 1;
    for (int f = 0; f < 40; f++) begin
      int nl;
      rand_ports_set();
      vsync_pulse();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        fill_line(($urandom_range(0, 5) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 10));
        send_line(1'b0);
      end
    end
    rand_ports = 0;
    vsync_pulse();
    chk("final_frame_cnt", frame_cnt, FW'(fcnt_m));
    chk("final_write_queue", exp_q.size(), 0);
    chk("final_line_err", lerr_obs, exp_lerr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
